// File: rtl/seg7_display_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg7_display_ctrl_if
//   Digit handshake between the seconds counter (source) and the 7-segment
//   display controller (sink). A digit moves on a rising clock edge where
//   digit_valid and digit_ready are both high. The source must hold
//   digit_in stable until that edge.
//
//   Signals
//     digit_in     4  BCD digit, 10..15 shows as blank
//     digit_valid  1  digit_in carries a digit this cycle
//     digit_ready  1  sink can take a digit this cycle
//
//   Modports
//     master : source side (drives digit_in / digit_valid)
//     slave  : sink side   (drives digit_ready)
// ----------------------------------------------------------------------------
interface seg7_display_ctrl_if;

    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;

    modport master (
        output digit_in,
        output digit_valid,
        input  digit_ready
    );

    modport slave (
        input  digit_in,
        input  digit_valid,
        output digit_ready
    );

endinterface : seg7_display_ctrl_if

// File: rtl/seg7_display_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_display_ctrl
//   Display stage behind the seconds counter. Takes one BCD digit per
//   handshake and drives a single 7-segment digit with these features:
//     - PWM brightness: each frame has 8 phases of PWM_DIV clocks. The digit
//       is lit while phase <= brightness.
//     - optional blink: the display goes dark on alternate blink half-periods.
//       Each half-period lasts BLINK_FRAMES PWM frames.
//     - anti-ghost blanking: the display is forced dark for BLANK_CYCLES
//       clocks after each accepted digit. No new digit is taken in that time.
//     - decimal-point flash: dp stays high for DP_HOLD clocks after each
//       accepted digit. A new digit restarts the flash.
//
//   Parameters
//     PWM_DIV       clocks per PWM phase (>= 1)
//     BLANK_CYCLES  dark clocks after each accepted digit (>= 1)
//     BLINK_FRAMES  PWM frames per blink half-period (>= 1)
//     DP_HOLD       clocks dp stays high after each accepted digit (>= 1)
//
//   Ports
//     clk          in   system clock
//     reset        in   asynchronous, active-high reset
//     digit_if     -    handshake (slave): digit_in, digit_valid, digit_ready
//     brightness   in   3-bit duty select, lit for (brightness+1)/8 of a frame
//     blink_en     in   1 = blink the display
//     segments     out  registered, active-high, bit0 = a .. bit6 = g
//     dp           out  registered decimal point, active-high
// ----------------------------------------------------------------------------
module seg7_display_ctrl #(
    parameter int unsigned PWM_DIV      = 16,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned DP_HOLD      = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    seg7_display_ctrl_if.slave        digit_if,
    input  logic [2:0]                brightness,
    input  logic                      blink_en,
    output logic [6:0]                segments,
    output logic                      dp
);

    // ------------------------------------------------------------------------
    // Counter widths. Each counter is at least one bit wide, so a parameter
    // value of 1 still gives a legal vector.
    // ------------------------------------------------------------------------
    localparam int PRE_W = (PWM_DIV      > 1) ? $clog2(PWM_DIV)      : 1;
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DPT_W = $clog2(DP_HOLD + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LOAD  = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [DPT_W-1:0] DPT_LOAD  = DPT_W'(DP_HOLD);
    localparam logic [2:0]       PHASE_MAX = 3'd7;

    // FSM encoding
    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    // Value held for a blank display, also loaded at reset
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // ------------------------------------------------------------------------
    // BCD to 7-segment decode, active-high, bit0 = a .. bit6 = g.
    // Codes 10..15 are not BCD digits and decode to all segments off.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       state;
    logic [3:0]       held_digit;
    logic [BLK_W-1:0] blank_cnt;
    logic [DPT_W-1:0] dp_timer;

    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       phase;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    logic             xfer;
    logic             pre_wrap;
    logic             frame_wrap;
    logic             pwm_on;
    logic             blink_off;
    logic [6:0]       seg_next;

    // digit_ready depends only on the FSM state, so it never forms a
    // combinational path back to digit_valid.
    assign digit_if.digit_ready = (state == ST_SHOW);
    assign xfer                 = digit_if.digit_valid && digit_if.digit_ready;

    // ------------------------------------------------------------------------
    // Handshake FSM, held digit and blanking counter.
    // SHOW accepts a digit and moves to BLANK for exactly BLANK_CYCLES clocks.
    // The counter is loaded with BLANK_CYCLES-1. BLANK leaves on the clock
    // where the counter is already zero.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every register samples values from before the edge, whatever the
    // order of the statements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_SHOW;
            held_digit <= DIGIT_BLANK;
            blank_cnt  <= '0;
        end else begin
            case (state)
                ST_SHOW: begin
                    if (xfer) begin
                        state      <= ST_BLANK;
                        held_digit <= digit_if.digit_in;
                        blank_cnt  <= BLK_LOAD;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt == '0) begin
                        state <= ST_SHOW;
                    end else begin
                        blank_cnt <= blank_cnt - BLK_W'(1);
                    end
                end
                default: begin
                    state <= ST_SHOW;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Decimal-point timer. Every accepted digit reloads the timer, even while
    // it is still running, so back-to-back digits keep dp high without a gap.
    // Once the timer reaches zero it stays at zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_timer <= '0;
        end else if (xfer) begin
            dp_timer <= DPT_LOAD;
        end else if (dp_timer != '0) begin
            dp_timer <= dp_timer - DPT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // PWM timebase. It runs freely and accepted digits do not restart it, so
    // the duty cycle is not disturbed by the digit rate.
    // ------------------------------------------------------------------------
    assign pre_wrap   = (pre_cnt == PRE_LAST);
    assign frame_wrap = pre_wrap && (phase == PHASE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            phase   <= '0;
        end else begin
            if (pre_wrap) begin
                pre_cnt <= '0;
                phase   <= phase + 3'd1;   // wraps 7 -> 0 by width
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Blink timebase. It counts whole PWM frames and flips blink_phase every
    // BLINK_FRAMES frames. The display is dark while blink_phase is high.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output gating. brightness = 7 gives phase <= 7 on every phase, so the
    // display is always lit. brightness and blink_en are used as they are,
    // with no glitch filtering. A change shows up in the next registered
    // segment value.
    // ------------------------------------------------------------------------
    assign pwm_on    = (phase <= brightness);
    assign blink_off = blink_en && blink_phase;

    // NOTE: a combinational block assigns its output a default before any
    // condition, so that no path through it can infer a latch.
    always_comb begin
        seg_next = 7'h00;
        if ((state == ST_SHOW) && pwm_on && !blink_off) begin
            seg_next = decode(held_digit);
        end
    end

    // Registered pins. Segments and dp follow state, PWM and the timers one
    // clock later. Reset drives both pins low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments <= 7'h00;
            dp       <= 1'b0;
        end else begin
            segments <= seg_next;
            dp       <= (dp_timer != '0);
        end
    end

endmodule : seg7_display_ctrl
